// File: rtl/instruction_sequencer.sv
// Purpose: fetch/decode/execute control FSM sitting between instruction memory,
//          the ALU and the program counter. Fetches one instruction per pass via
//          a req/ready handshake, launches the ALU for ALU ops, and strobes the
//          PC exactly once per retired instruction.
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   start                   leave IDLE and begin fetching
//   mem_ready, instr_in     instruction memory handshake / data
//   alu_done                ALU completion for the op launched by alu_start
//   mem_req                 fetch request, high for every FETCH cycle
//   instr_reg               latched current instruction
//   pc_enable/jump/jz       PC advance strobe and its qualifiers
//   jump_address            low byte of instr_reg
//   alu_start, reg_write    one-cycle ALU launch / register write strobes
//   halted, fault           sticky HALT and ALU-timeout flags
//   retired                 saturating retired-instruction count
//   state                   current FSM state (debug)
module instruction_sequencer #(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               alu_done,
  output logic               mem_req,
  output logic [INSTR_W-1:0] instr_reg,
  output logic               pc_enable,
  output logic               pc_jump,
  output logic               pc_jz,
  output logic [ADDR_W-1:0]  jump_address,
  output logic               alu_start,
  output logic               reg_write,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        retired,
  output logic [2:0]         state
);

  localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ALU_TIMEOUT);
  localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_JZ  = 4'h3;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXECUTE  = 3'd3,
    S_WAIT_ALU = 3'd4,
    S_ADVANCE  = 3'd5,
    S_HALT     = 3'd6
  } state_e;

  state_e               r_state;
  logic [INSTR_W-1:0]   r_instr;
  logic [15:0]          r_retired;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_fault;

  logic [3:0]           w_op;
  logic [CNT_W-1:0]     w_cnt_inc;

  assign w_op      = r_instr[INSTR_W-1 -: 4];
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State register plus the few datapath registers the FSM owns.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_retired <= '0;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_instr <= instr_in;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (w_op)
            OP_ALU:  r_state <= S_EXECUTE;
            OP_HLT:  r_state <= S_HALT;
            default: r_state <= S_ADVANCE;  // NOP, JMP, JZ and unused opcodes
          endcase
        end
        S_EXECUTE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_ALU;
        end
        S_WAIT_ALU: begin
          if (alu_done) begin
            r_state <= S_ADVANCE;
          end else begin
            r_cnt <= w_cnt_inc;
            // Counter reaching the limit means ALU_TIMEOUT cycles spent here.
            if (w_cnt_inc == TIMEOUT_VAL) begin
              r_fault <= 1'b1;
              r_state <= S_HALT;
            end
          end
        end
        S_ADVANCE: begin
          if (r_retired != RETIRED_MAX) r_retired <= r_retired + 16'd1;
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode from the state register; reg_write must coincide with
  // alu_done, so it is the one strobe that also looks at an input.
  assign mem_req      = (r_state == S_FETCH);
  assign alu_start    = (r_state == S_EXECUTE);
  assign reg_write    = (r_state == S_WAIT_ALU) && alu_done;
  assign pc_enable    = (r_state == S_ADVANCE);
  assign pc_jump      = (r_state == S_ADVANCE) && (w_op == OP_JMP);
  assign pc_jz        = (r_state == S_ADVANCE) && (w_op == OP_JZ);
  assign halted       = (r_state == S_HALT);
  assign fault        = r_fault;
  assign instr_reg    = r_instr;
  assign jump_address = r_instr[ADDR_W-1:0];
  assign retired      = r_retired;
  assign state        = r_state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Purpose: randomized self-checking bench for instruction_sequencer. Drives
//          instructions with random fetch stalls and ALU latencies, builds the
//          expected per-cycle outputs from instruction-level timing rules, and
//          models the program counter the sequencer would drive.
module tb_instruction_sequencer;

  localparam int unsigned T = 15;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] instr_in = 16'h0;
  logic        alu_done = 1'b0;
  logic        mem_req;
  logic [15:0] instr_reg;
  logic        pc_enable, pc_jump, pc_jz;
  logic [7:0]  jump_address;
  logic        alu_start, reg_write, halted, fault;
  logic [15:0] retired;
  logic [2:0]  state;

  logic        zero_flag = 1'b0;
  logic [7:0]  pc;

  instruction_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mem_ready(mem_ready),
    .instr_in(instr_in), .alu_done(alu_done), .mem_req(mem_req),
    .instr_reg(instr_reg), .pc_enable(pc_enable), .pc_jump(pc_jump),
    .pc_jz(pc_jz), .jump_address(jump_address), .alu_start(alu_start),
    .reg_write(reg_write), .halted(halted), .fault(fault),
    .retired(retired), .state(state)
  );

  always #5 clock = ~clock;

  // Program counter driven by the sequencer's strobes; wraps 127 -> 0.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc <= 8'd0;
    else if (pc_enable) begin
      if (pc_jump || (pc_jz && zero_flag)) pc <= jump_address;
      else pc <= (pc == 8'd127) ? 8'd0 : pc + 8'd1;
    end
  end

  typedef struct packed {
    logic [2:0]  st;
    logic        mem_req, alu_start, reg_write, pc_enable, pc_jump, pc_jz, halted, fault;
    logic [15:0] retired;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [7:0]  ja;
  } exp_t;

  typedef struct {
    int          sel;
    logic [31:0] req;
    string       nm;
  } lit_t;

  localparam int L_CTRL = 0, L_RET = 1, L_INSTR = 2, L_PC = 3, L_MPC = 4,
                 L_MRET = 5, L_HALT = 6, L_FAULT = 7;

  exp_t q[$];
  lit_t lit_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Instruction-level model state.
  logic [15:0] m_retired, m_instr;
  logic [7:0]  m_pc;
  logic        m_fault;

  exp_t        ce, ca;
  lit_t        cl;
  logic [31:0] la;

  // Single compare process: per-cycle trace entries plus queued spot checks.
  always @(negedge clock) begin
    if (q.size() != 0) begin
      ce = q.pop_front();
      ca = {state, mem_req, alu_start, reg_write, pc_enable, pc_jump, pc_jz,
            halted, fault, retired, instr_reg, pc, jump_address};
      vectors++;
      if (ca !== ce) begin
        miscompares++;
        $display("FAIL cycle_trace t=%0t state act=%0d req=%0d actual=%h required=%h",
                 $time, ca.st, ce.st, ca, ce);
      end
    end
    while (lit_q.size() != 0) begin
      cl = lit_q.pop_front();
      case (cl.sel)
        L_CTRL:  la = 32'({state, mem_req, alu_start, reg_write, pc_enable,
                           pc_jump, pc_jz, halted, fault});
        L_RET:   la = 32'(retired);
        L_INSTR: la = 32'({instr_reg, jump_address});
        L_PC:    la = 32'(pc);
        L_MPC:   la = 32'(m_pc);
        L_MRET:  la = 32'(m_retired);
        L_HALT:  la = 32'(halted);
        default: la = 32'(fault);
      endcase
      vectors++;
      if (la !== cl.req) begin
        miscompares++;
        $display("FAIL %s t=%0t actual=%h required=%h", cl.nm, $time, la, cl.req);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st      = st;
    e.halted  = (st == 3'd6);
    e.fault   = m_fault;
    e.retired = m_retired;
    e.instr   = m_instr;
    e.pc      = m_pc;
    e.ja      = m_instr[7:0];
    return e;
  endfunction

  task automatic lit(input int sel, input logic [31:0] req, input string nm);
    lit_t l;
    l.sel = sel; l.req = req; l.nm = nm;
    lit_q.push_back(l);
  endtask

  task automatic cyc(input logic s, input logic mr, input logic [15:0] ii,
                     input logic ad, input exp_t e);
    @(posedge clock); #1;
    start = s; mem_ready = mr; instr_in = ii; alu_done = ad;
    q.push_back(e);
  endtask

  task automatic model_clear();
    m_retired = 16'h0; m_instr = 16'h0; m_pc = 8'h0; m_fault = 1'b0;
  endtask

  // Async reset mid-cycle; outputs must be zero before the next clock edge.
  task automatic do_reset();
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    q.delete();
    start = 1'b0; mem_ready = 1'b0; alu_done = 1'b0;
    lit(L_CTRL, 32'h0, "reset_ctrl");
    lit(L_RET, 32'h0, "reset_retired");
    lit(L_INSTR, 32'h0, "reset_instr");
    @(negedge clock); #2;
    model_clear();
    reset_n = 1'b1;
  endtask

  task automatic start_seq();
    exp_t e;
    repeat (2) begin e = base(3'd0); cyc(1'b0, rbit(), 16'($urandom), rbit(), e); end
    e = base(3'd0); cyc(1'b1, rbit(), 16'($urandom), rbit(), e);
  endtask

  // One instruction: w stall cycles in fetch, ALU done after k cycles (k=0: never).
  task automatic do_instr(input logic [15:0] ins, input int w, input int k, input logic z);
    exp_t e;
    logic [3:0] op;
    op = ins[15:12];
    for (int i = 0; i <= w; i++) begin
      e = base(3'd1); e.mem_req = 1'b1;
      cyc(rbit(), (i == w), (i == w) ? ins : 16'($urandom), rbit(), e);
    end
    m_instr = ins;
    zero_flag = z;
    e = base(3'd2);
    cyc(rbit(), rbit(), 16'($urandom), rbit(), e);
    if (op == 4'hF) begin
      repeat (4) begin e = base(3'd6); cyc(rbit(), rbit(), 16'($urandom), rbit(), e); end
      return;
    end
    if (op == 4'h1) begin
      e = base(3'd3); e.alu_start = 1'b1;
      cyc(rbit(), rbit(), 16'($urandom), rbit(), e);
      if (k == 0) begin
        for (int j = 1; j <= int'(T); j++) begin
          e = base(3'd4); cyc(rbit(), rbit(), 16'($urandom), 1'b0, e);
        end
        m_fault = 1'b1;
        repeat (4) begin e = base(3'd6); cyc(1'b1, rbit(), 16'($urandom), rbit(), e); end
        return;
      end
      for (int j = 1; j <= k; j++) begin
        e = base(3'd4); e.reg_write = (j == k);
        cyc(rbit(), rbit(), 16'($urandom), (j == k), e);
      end
    end
    e = base(3'd5);
    e.pc_enable = 1'b1; e.pc_jump = (op == 4'h2); e.pc_jz = (op == 4'h3);
    cyc(rbit(), rbit(), 16'($urandom), rbit(), e);
    if (m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
    if (op == 4'h2 || (op == 4'h3 && z)) m_pc = ins[7:0];
    else m_pc = (m_pc == 8'd127) ? 8'd0 : m_pc + 8'd1;
  endtask

  // One stalled fetch cycle, then pin DUT PC/retired and the model to constants.
  task automatic hold_chk(input logic [7:0] epc, input logic [15:0] eret, input string nm);
    exp_t e;
    e = base(3'd1); e.mem_req = 1'b1;
    cyc(rbit(), 1'b0, 16'($urandom), rbit(), e);
    lit(L_PC, 32'(epc), {nm, "_pc"});
    lit(L_RET, 32'(eret), {nm, "_retired"});
    lit(L_MPC, 32'(epc), {nm, "_model_pc"});
    lit(L_MRET, 32'(eret), {nm, "_model_retired"});
  endtask

  initial begin
    exp_t e;
    logic [15:0] ri;
    model_clear();
    do_reset();

    start_seq();
    repeat (3) do_instr(16'h0000, 0, 0, 1'b0);
    hold_chk(8'd3, 16'd3, "nop3");
    do_instr(16'h2042, 0, 0, 1'b0);
    hold_chk(8'h42, 16'd4, "jmp42");
    do_instr(16'h3010, 0, 0, 1'b1);
    hold_chk(8'h10, 16'd5, "jz_taken");
    do_instr(16'h3055, 1, 0, 1'b0);
    hold_chk(8'h11, 16'd6, "jz_not_taken");
    do_instr(16'h207F, 0, 0, 1'b0);
    do_instr(16'h0000, 0, 0, 1'b0);
    hold_chk(8'h00, 16'd8, "pc_wrap");
    do_instr(16'h1305, 0, 4, 1'b0);
    hold_chk(8'h01, 16'd9, "alu_k4");
    do_instr(16'h1111, 2, int'(T), 1'b0);
    hold_chk(8'h02, 16'd10, "alu_kmax");

    for (int n = 0; n < 200; n++) begin
      ri = {4'($urandom_range(0, 14)), 4'($urandom), 1'b0, 7'($urandom)};
      do_instr(ri, $urandom_range(0, 2), $urandom_range(1, T), rbit());
    end
    e = base(3'd1); e.mem_req = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0, e);
    lit(L_PC, 32'(m_pc), "random_pc");
    lit(L_RET, 32'(m_retired), "random_retired");

    do_instr(16'h1ABC, 0, 0, 1'b0);
    lit(L_HALT, 32'h1, "timeout_halted");
    lit(L_FAULT, 32'h1, "timeout_fault");
    lit(L_PC, 32'(m_pc), "timeout_pc_held");

    do_reset();
    start_seq();
    repeat (5) begin
      e = base(3'd1); e.mem_req = 1'b1;
      cyc(rbit(), 1'b0, 16'($urandom), rbit(), e);
    end
    do_reset();

    start_seq();
    e = base(3'd1); e.mem_req = 1'b1; cyc(1'b0, 1'b1, 16'h1305, 1'b0, e);
    m_instr = 16'h1305;
    e = base(3'd2); cyc(1'b0, 1'b0, 16'h0, 1'b1, e);
    e = base(3'd3); e.alu_start = 1'b1; cyc(1'b0, 1'b0, 16'h0, 1'b1, e);
    repeat (3) begin e = base(3'd4); cyc(1'b0, 1'b0, 16'h0, 1'b0, e); end
    do_reset();

    start_seq();
    do_instr(16'hF000, 0, 0, 1'b0);
    lit(L_HALT, 32'h1, "hlt_halted");
    lit(L_FAULT, 32'h0, "hlt_fault");

    @(negedge clock); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
